// File: rtl/stopwatch_sseg_amisha_pkg.sv
// Shared seven-segment constants for the stopwatch and the display mux benches.
// Segment order {dp,g,f,e,d,c,b,a}, active-low; dp is dark in every pattern.
package stopwatch_sseg_amisha_pkg;

    localparam logic [7:0] SSEG_0 = 8'hC0;
    localparam logic [7:0] SSEG_1 = 8'hF9;
    localparam logic [7:0] SSEG_2 = 8'hA4;
    localparam logic [7:0] SSEG_3 = 8'hB0;
    localparam logic [7:0] SSEG_4 = 8'h99;
    localparam logic [7:0] SSEG_5 = 8'h92;
    localparam logic [7:0] SSEG_6 = 8'h82;
    localparam logic [7:0] SSEG_7 = 8'hF8;
    localparam logic [7:0] SSEG_8 = 8'h80;
    localparam logic [7:0] SSEG_9 = 8'h90;
    localparam logic [7:0] SSEG_A = 8'h88;
    localparam logic [7:0] SSEG_B = 8'h83;
    localparam logic [7:0] SSEG_C = 8'hC6;
    localparam logic [7:0] SSEG_D = 8'hA1;
    localparam logic [7:0] SSEG_E = 8'h86;
    localparam logic [7:0] SSEG_F = 8'h8E;

    localparam logic [7:0] SSEG_BLANK  = 8'hFF;
    localparam int         SSEG_DP_BIT = 7;

endpackage

// File: rtl/stopwatch_sseg_amisha_hex_to_sseg.sv
// hex_to_sseg_amisha: combinational hex digit plus decimal point to an
// active-low seven-segment pattern.
module hex_to_sseg_amisha
    import stopwatch_sseg_amisha_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] sseg
);

    logic [7:0] pattern;

    always_comb begin
        pattern = SSEG_BLANK;
        case (hex)
            4'h0: pattern = SSEG_0;
            4'h1: pattern = SSEG_1;
            4'h2: pattern = SSEG_2;
            4'h3: pattern = SSEG_3;
            4'h4: pattern = SSEG_4;
            4'h5: pattern = SSEG_5;
            4'h6: pattern = SSEG_6;
            4'h7: pattern = SSEG_7;
            4'h8: pattern = SSEG_8;
            4'h9: pattern = SSEG_9;
            4'hA: pattern = SSEG_A;
            4'hB: pattern = SSEG_B;
            4'hC: pattern = SSEG_C;
            4'hD: pattern = SSEG_D;
            4'hE: pattern = SSEG_E;
            4'hF: pattern = SSEG_F;
            default: pattern = SSEG_BLANK;
        endcase
    end

    // dp input is active-high "lit"; the segment line is active-low
    always_comb begin
        sseg = pattern;
        sseg[SSEG_DP_BIT] = ~dp;
    end

endmodule

// File: rtl/stopwatch_sseg_amisha.sv
// Four-digit BCD stopwatch (000.0..999.9 s) with registered seven-segment outputs.
// Optional macro STOPWATCH_LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3 and 2.
module stopwatch_sseg_amisha
    import stopwatch_sseg_amisha_pkg::*;
#(
    parameter int TICK_DIV = 5000000,
    parameter int CNT_W    = 23
) (
    input  logic        clk_amisha,
    input  logic        reset_amisha,
    input  logic        go_amisha,
    input  logic        clr_amisha,
    output logic [7:0]  sseg3_amisha,
    output logic [7:0]  sseg2_amisha,
    output logic [7:0]  sseg1_amisha,
    output logic [7:0]  sseg0_amisha,
    output logic [15:0] bcd_amisha,
    output logic        wrap_amisha
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0] SSEG_0_DP = SSEG_0 & ~(8'h01 << SSEG_DP_BIT);

`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] RST_SSEG3 = SSEG_BLANK;
    localparam logic [7:0] RST_SSEG2 = SSEG_BLANK;
`else
    localparam logic [7:0] RST_SSEG3 = SSEG_0;
    localparam logic [7:0] RST_SSEG2 = SSEG_0;
`endif

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [15:0]      bcd_q;
    logic [15:0]      bcd_inc;
    logic             all_nines;
    logic [7:0]       raw3, raw2, raw1, raw0;
    logic             blank3, blank2;

    assign tick       = go_amisha && (cnt == TICK_LAST);
    assign bcd_amisha = bcd_q;

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            cnt <= '0;
        end else if (clr_amisha) begin
            cnt <= '0;
        end else if (go_amisha) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    // Ripple-carry BCD increment; a carry surviving all four digits means 999.9
    always_comb begin
        logic carry;
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_q[i*4 +: 4] == 4'd9) begin
                    bcd_inc[i*4 +: 4] = 4'd0;
                end else begin
                    bcd_inc[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            bcd_q       <= '0;
            wrap_amisha <= 1'b0;
        end else if (clr_amisha) begin
            bcd_q       <= '0;
            wrap_amisha <= 1'b0;
        end else begin
            if (tick) begin
                bcd_q <= bcd_inc;
            end
            wrap_amisha <= tick && all_nines;
        end
    end

    hex_to_sseg_amisha u_dec3 (.hex(bcd_q[15:12]), .dp(1'b0), .sseg(raw3));
    hex_to_sseg_amisha u_dec2 (.hex(bcd_q[11:8]),  .dp(1'b0), .sseg(raw2));
    hex_to_sseg_amisha u_dec1 (.hex(bcd_q[7:4]),   .dp(1'b1), .sseg(raw1));
    hex_to_sseg_amisha u_dec0 (.hex(bcd_q[3:0]),   .dp(1'b0), .sseg(raw0));

`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
    assign blank3 = (bcd_q[15:12] == 4'd0);
    assign blank2 = blank3 && (bcd_q[11:8] == 4'd0);
`else
    assign blank3 = 1'b0;
    assign blank2 = 1'b0;
`endif

    // Segment outputs trail the digit register by one cycle
    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            sseg3_amisha <= RST_SSEG3;
            sseg2_amisha <= RST_SSEG2;
            sseg1_amisha <= SSEG_0_DP;
            sseg0_amisha <= SSEG_0;
        end else begin
            sseg3_amisha <= blank3 ? SSEG_BLANK : raw3;
            sseg2_amisha <= blank2 ? SSEG_BLANK : raw2;
            sseg1_amisha <= raw1;
            sseg0_amisha <= raw0;
        end
    end

endmodule
